// File: rtl/dma_pkg.sv
// Shared types and defaults for the IO-to-memory DMA channel.
// Holds the channel state encoding and default sizing constants.
package dma_pkg;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_ADDR_W     = 16;
    localparam int DATA_W         = 32;
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } dma_state_t;

endpackage

// File: rtl/dma_fifo.sv
// Capture FIFO between the IO source and the memory write port.
// A push while full succeeds only when a pop happens on the same edge.
module dma_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int W     = DATA_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    // Qualify requests against current occupancy.
    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != FULL_CNT) || do_pop);
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy; power-of-2 depth lets pointers wrap freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/dma_io_channel.sv
// IO capture DMA channel: buffers strobed IO words and writes them
// to consecutive memory word addresses while holding the bus grant.
module dma_io_channel
    import dma_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          new_data_ready,
    input  logic [31:0]                   io_data,
    input  logic                          cfg_start,
    input  logic [ADDR_W-1:0]             cfg_base,
    input  logic [15:0]                   cfg_len,
    output logic                          bus_req,
    input  logic                          bus_grant,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    dma_state_t           state;
    logic [ADDR_W-1:0]    base_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     written;
    logic [LEN_W-1:0]     written_inc;
    logic [LEN_W-1:0]     accepted;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_W-1:0]    fifo_head;
    logic                 start_ok;
    logic                 can_take;
    logic                 push;
    logic                 pop;
    logic                 drop_full;

    // Capture admission and pop decisions for this cycle.
    always_comb begin
        start_ok    = cfg_start && (state == ST_IDLE);
        can_take    = busy && (accepted < len_q);
        pop         = (state == ST_XFER) && bus_grant && !fifo_empty;
        push        = new_data_ready && can_take && (!fifo_full || pop);
        drop_full   = new_data_ready && can_take && fifo_full && !pop;
        written_inc = written + 1'b1;
    end

    assign bus_req = (state == ST_REQ) || (state == ST_XFER);

    dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (io_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Accepted-word counter and sticky overflow, cleared on a new transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accepted <= '0;
            overflow <= 1'b0;
        end else if (start_ok) begin
            accepted <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                accepted <= accepted + 1'b1;
            end
            if (drop_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Channel FSM with registered write port and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            written   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        base_q  <= cfg_base;
                        len_q   <= cfg_len;
                        written <= '0;
                        busy    <= 1'b1;
                        state   <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (len_q == '0) begin
                        state <= ST_DONE;
                    end else if (!fifo_empty) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_grant) begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!bus_grant) begin
                        state <= ST_REQ;
                    end else if (!fifo_empty) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= base_q + ADDR_W'(written);
                        mem_wdata <= fifo_head;
                        written   <= written_inc;
                        if (written_inc == len_q) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        state <= ST_ARMED;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_io_channel.sv
// Self-checking bench for dma_io_channel: table-driven transfers,
// directed corner sequences and a randomized run against a queue model.
module tb_dma_io_channel;

    localparam int DEPTH = 4;
    localparam int AW    = 16;

    logic          clk;
    logic          reset;
    logic          new_data_ready;
    logic [31:0]   io_data;
    logic          cfg_start;
    logic [AW-1:0] cfg_base;
    logic [15:0]   cfg_len;
    logic          bus_req;
    logic          bus_grant;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [2:0]    fifo_count;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [AW-1:0] wq_addr [$];
    logic [31:0]   wq_data [$];

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        int          nstrobe;
        int          exp_writes;
        logic [15:0] exp_last;
        logic        exp_ov;
    } vec_t;

    vec_t tbl [4];

    dma_io_channel #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .new_data_ready (new_data_ready),
        .io_data        (io_data),
        .cfg_start      (cfg_start),
        .cfg_base       (cfg_base),
        .cfg_len        (cfg_len),
        .bus_req        (bus_req),
        .bus_grant      (bus_grant),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
        if (done) done_cnt++;
    endtask

    task automatic start(input logic [15:0] b, input logic [15:0] l);
        cfg_start = 1'b1;
        cfg_base  = b;
        cfg_len   = l;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] d);
        new_data_ready = 1'b1;
        io_data        = d;
        tick();
        new_data_ready = 1'b0;
    endtask

    task automatic wait_idle(input int n, input string tag);
        for (int c = 0; c < n && busy; c++) tick();
        chk({tag, " idle"}, busy, 0);
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " bus_req"}, bus_req, 0);
        chk({tag, " mem_we"}, mem_we, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " overflow"}, overflow, 0);
        chk({tag, " fifo_count"}, fifo_count, 0);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #1;
        check_zero(tag);
        tick();
        tick();
        reset = 1'b1;
        clear_log();
    endtask

    task automatic run_random(input int ntr);
        logic [31:0] q [$];
        logic [15:0] b;
        logic [15:0] l;
        logic [31:0] dv;
        logic [31:0] exp_d;
        logic        sd;
        logic        g;
        logic        mb;
        logic        mb_prev;
        logic        ov;
        logic        pend;
        logic        fin;
        logic        popped;
        int          acc;
        int          wr;
        int          qs;
        for (int t = 0; t < ntr; t++) begin
            b = 16'($urandom);
            l = 16'($urandom_range(1, 12));
            bus_grant = 1'b0;
            new_data_ready = 1'b0;
            start(b, l);
            q.delete();
            acc = 0; wr = 0; mb = 1'b1; ov = 1'b0;
            pend = 1'b0; fin = 1'b0;
            for (int c = 0; c < 600 && !fin; c++) begin
                sd = ($urandom_range(0, 99) < 45);
                dv = $urandom;
                g  = ($urandom_range(0, 99) < 70);
                new_data_ready = sd;
                io_data = dv;
                bus_grant = g;
                mb_prev = mb;
                tick();
                if (pend) begin
                    chk("rnd done", done, 1);
                    mb = 1'b0; fin = 1'b1; pend = 1'b0;
                end else begin
                    chk("rnd done", done, 0);
                end
                qs = q.size();
                popped = mem_we;
                if (mem_we) begin
                    chk("rnd grant", g, 1);
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rnd pop: write %0h with empty model queue",
                                 mem_wdata);
                    end else begin
                        exp_d = q.pop_front();
                        chk("rnd addr", mem_addr, 16'(b + 16'(wr)));
                        chk("rnd data", mem_wdata, exp_d);
                    end
                    wr++;
                    if (wr == int'(l)) pend = 1'b1;
                end
                if (sd && mb_prev && acc < int'(l)) begin
                    if (qs < DEPTH || popped) begin
                        q.push_back(dv);
                        acc++;
                    end else begin
                        ov = 1'b1;
                    end
                end
                chk("rnd fifo_count", fifo_count, q.size());
                chk("rnd overflow", overflow, ov);
                chk("rnd busy", busy, mb);
            end
            new_data_ready = 1'b0;
            if (!fin) begin
                checks++; errors++;
                $display("FAIL rnd timeout: written %0d of %0d", wr, l);
            end
            chk("rnd written", wr, l);
            tick();
        end
    endtask

    initial begin
        tbl[0] = '{16'h0100, 16'd3, 3, 3, 16'h0102, 1'b0};
        tbl[1] = '{16'hFFFF, 16'd2, 2, 2, 16'h0000, 1'b0};
        tbl[2] = '{16'h1234, 16'd1, 3, 1, 16'h1234, 1'b0};
        tbl[3] = '{16'h0040, 16'd0, 2, 0, 16'h0000, 1'b0};

        reset = 1'b0;
        new_data_ready = 1'b0;
        io_data = '0;
        cfg_start = 1'b0;
        cfg_base = '0;
        cfg_len = '0;
        bus_grant = 1'b0;
        tick();
        tick();
        check_zero("reset");
        reset = 1'b1;
        tick();

        // table-driven transfers, grant held, strobes every 8 cycles
        for (int i = 0; i < 4; i++) begin
            clear_log();
            bus_grant = 1'b1;
            start(tbl[i].base, tbl[i].len);
            chk("tbl busy", busy, 1);
            for (int s = 0; s < tbl[i].nstrobe; s++) begin
                strobe(32'(s + 1));
                repeat (7) tick();
            end
            wait_idle(60, "tbl");
            chk("tbl writes", wq_addr.size(), tbl[i].exp_writes);
            for (int j = 0; j < wq_addr.size(); j++) begin
                chk("tbl addr", wq_addr[j], 16'(tbl[i].base + 16'(j)));
                chk("tbl data", wq_data[j], j + 1);
            end
            if (wq_addr.size() > 0)
                chk("tbl last addr", wq_addr[wq_addr.size()-1], tbl[i].exp_last);
            chk("tbl done pulses", done_cnt, 1);
            chk("tbl overflow", overflow, tbl[i].exp_ov);
            chk("tbl fifo_count", fifo_count, 0);
        end

        // latency: push at edge k appears after edge k+3
        clear_log();
        bus_grant = 1'b1;
        start(16'h0200, 16'd1);
        tick();
        new_data_ready = 1'b1;
        io_data = 32'h0000ABCD;
        tick();
        new_data_ready = 1'b0;
        chk("lat k count", fifo_count, 1);
        chk("lat k bus_req", bus_req, 0);
        chk("lat k mem_we", mem_we, 0);
        tick();
        chk("lat k+1 bus_req", bus_req, 1);
        chk("lat k+1 mem_we", mem_we, 0);
        tick();
        chk("lat k+2 mem_we", mem_we, 0);
        tick();
        chk("lat k+3 mem_we", mem_we, 1);
        chk("lat k+3 addr", mem_addr, 16'h0200);
        chk("lat k+3 data", mem_wdata, 32'h0000ABCD);
        chk("lat k+3 count", fifo_count, 0);
        tick();
        chk("lat done", done, 1);
        chk("lat busy", busy, 0);
        tick();
        chk("lat done width", done, 0);

        // overflow: no grant, 6 strobes into a 4-deep FIFO
        clear_log();
        bus_grant = 1'b0;
        start(16'h0300, 16'd8);
        for (int s = 0; s < 6; s++) strobe(32'(s + 1));
        chk("ovf count", fifo_count, 4);
        chk("ovf flag", overflow, 1);
        chk("ovf bus_req", bus_req, 1);
        chk("ovf writes", wq_addr.size(), 0);
        pulse_reset("ovf reset");

        // simultaneous push and pop while full
        bus_grant = 1'b0;
        start(16'h0400, 16'd8);
        for (int s = 0; s < 4; s++) strobe(32'(s + 1));
        chk("pp full count", fifo_count, 4);
        chk("pp full ovf", overflow, 0);
        bus_grant = 1'b1;
        tick();
        strobe(32'd5);
        chk("pp mem_we", mem_we, 1);
        chk("pp data", mem_wdata, 1);
        chk("pp count", fifo_count, 4);
        chk("pp ovf", overflow, 0);
        for (int s = 5; s < 8; s++) strobe(32'(s + 1));
        wait_idle(60, "pp");
        chk("pp writes", wq_addr.size(), 8);
        for (int j = 0; j < wq_addr.size(); j++) begin
            chk("pp addr", wq_addr[j], 16'(16'h0400 + 16'(j)));
            chk("pp wdata", wq_data[j], j + 1);
        end
        chk("pp done pulses", done_cnt, 1);
        chk("pp final ovf", overflow, 0);

        // grant drop mid-XFER, plus a start that must be ignored
        clear_log();
        bus_grant = 1'b1;
        start(16'h0500, 16'd4);
        start(16'h0900, 16'd1);
        for (int s = 0; s < 4; s++) strobe(32'(16 + s));
        chk("gd first write", mem_we, 1);
        bus_grant = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("gd mem_we", mem_we, 0);
            chk("gd bus_req", bus_req, 1);
        end
        bus_grant = 1'b1;
        wait_idle(60, "gd");
        chk("gd writes", wq_addr.size(), 4);
        for (int j = 0; j < wq_addr.size(); j++) begin
            chk("gd addr", wq_addr[j], 16'(16'h0500 + 16'(j)));
            chk("gd data", wq_data[j], 16 + j);
        end
        chk("gd done pulses", done_cnt, 1);

        // len=0 timing, strobes in IDLE ignored
        clear_log();
        strobe(32'hDEAD);
        strobe(32'hBEEF);
        chk("z idle count", fifo_count, 0);
        start(16'h0600, 16'd0);
        chk("z s busy", busy, 1);
        chk("z s done", done, 0);
        tick();
        chk("z s+1 done", done, 0);
        tick();
        chk("z s+2 done", done, 1);
        chk("z s+2 busy", busy, 0);
        tick();
        chk("z writes", wq_addr.size(), 0);
        chk("z done pulses", done_cnt, 1);

        // reset after two of four words written
        clear_log();
        bus_grant = 1'b1;
        start(16'h0700, 16'd4);
        for (int s = 0; s < 4; s++) strobe(32'(32 + s));
        tick();
        chk("rst two written", wq_addr.size(), 2);
        pulse_reset("rst mid");
        strobe(32'h55);
        strobe(32'h66);
        chk("rst strobe ignored", fifo_count, 0);
        repeat (20) tick();
        chk("rst no writes", wq_addr.size(), 0);
        chk("rst busy", busy, 0);

        // randomized transfers against the queue model
        run_random(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_io_channel.md
DMA_IO_CHANNEL -- requirements
Module: dma_io_channel

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, capture FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port new_data_ready  in  1  one-cycle strobe from IO source; io_data valid in the same cycle.
REQ-006 SHALL have port io_data  in  32  IO source data word.
REQ-007 SHALL have port cfg_start  in  1  one-cycle pulse that arms a transfer.
REQ-008 SHALL have port cfg_base  in  ADDR_W  first destination word address, sampled on accepted cfg_start.
REQ-009 SHALL have port cfg_len  in  16  words to transfer, sampled on accepted cfg_start.
REQ-010 SHALL have port bus_req  out  1  memory bus request.
REQ-011 SHALL have port bus_grant  in  1  memory bus grant; may drop at any cycle.
REQ-012 SHALL have port mem_we  out  1  registered write strobe, one word per cycle.
REQ-013 SHALL have port mem_addr  out  ADDR_W  registered write address.
REQ-014 SHALL have port mem_wdata  out  32  registered write data.
REQ-015 SHALL have port busy  out  1  high from accepted cfg_start until DONE.
REQ-016 SHALL have port done  out  1  one-cycle completion pulse.
REQ-017 SHALL have port overflow  out  1  sticky dropped-word flag.
REQ-018 SHALL have port fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-019 SHALL implement states IDLE, ARMED, REQ, XFER, DONE.
REQ-020 IDLE: cfg_start latches base/len, clears overflow and counters, goes to ARMED; cfg_start in any other state SHALL be ignored.
REQ-021 new_data_ready SHALL push io_data only when busy, not full, and accepted count < len; otherwise the word is dropped, and overflow SHALL set if dropped because FIFO full.
REQ-022 Push and pop in the same cycle while full SHALL both succeed; no overflow.
REQ-023 ARMED with FIFO non-empty SHALL go to REQ; bus_req SHALL be high exactly in REQ and XFER.
REQ-024 REQ with bus_grant=1 SHALL go to XFER.
REQ-025 XFER with bus_grant=1 and FIFO non-empty SHALL pop one word, register mem_we=1, mem_addr=base+written, mem_wdata=head, and increment written; otherwise mem_we=0.
REQ-026 XFER with bus_grant=0 SHALL issue no write and return to REQ; XFER with FIFO empty and written<len SHALL return to ARMED.
REQ-027 written reaching len SHALL go to DONE; DONE SHALL assert done for one cycle, clear busy, return to IDLE.
REQ-028 cfg_len=0 SHALL go ARMED->DONE on the next edge with no write.
REQ-029 mem_addr SHALL wrap modulo 2^ADDR_W.
REQ-030 With bus_grant tied 1 and FIFO previously empty, a word pushed at edge k SHALL appear with mem_we=1 after edge k+3.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, empty FIFO, zero counters, and all outputs 0.
REQ-032 reset during XFER SHALL abort; no mem_we after reset release until a new cfg_start.

Structure
REQ-033 Shared package dma_pkg SHALL hold the state enum and default FIFO_DEPTH/ADDR_W constants.
REQ-034 FIFO SHALL be the sub-module dma_fifo (push/pop/full/empty/count).

Verification
REQ-035 start base=0x0100 len=3, grant=1, strobes every 8 cycles data 1,2,3 -> writes (0x0100,1),(0x0101,2),(0x0102,3), one done pulse.
REQ-036 grant=0, len=8, 6 strobes with FIFO_DEPTH=4 -> fifo_count=4, overflow=1, 2 words dropped.
REQ-037 base=0xFFFF len=2, grant=1 -> addresses 0xFFFF then 0x0000.
REQ-038 grant dropped for 3 cycles mid-XFER -> no mem_we in those cycles, bus_req stays 1, remaining words written in order.
REQ-039 len=0 -> done pulse 2 edges after start, no mem_we; strobes in IDLE ignored.
REQ-040 reset=0 after 2 of 4 words written -> all outputs 0 immediately, no further writes.
